// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute and the data-memory port: legality and
// alignment checks, one aligned 64-bit req/gnt/rvalid transaction, timeout fault.
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_func_3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]            o_mem_wstrb,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [2:0]            o_rsp_func_3,
    output logic [2:0]            o_rsp_addr_offset,
    output logic                  o_load_addr_ma,
    output logic                  o_store_addr_ma,
    output logic                  o_illegal_instr,
    output logic                  o_access_fault
);

    // state | meaning
    // IDLE  | ready for a new access
    // REQ   | o_mem_req held until grant
    // WAIT  | granted, waiting for rvalid
    // RESP  | response held until i_rsp_ready

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic                  we_q;
    logic [2:0]            func3_q;
    logic [2:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  load_ma_q;
    logic                  store_ma_q;
    logic                  illegal_q;
    logic                  fault_q;
    logic [CNT_W-1:0]      cnt_q;

    logic       accept;
    logic       timeout_hit;
    logic       expire;
    logic [2:0] off_in;
    logic       illegal_in;
    logic       misalign_in;
    logic [7:0] strb_in;

    always_comb begin
        off_in      = i_addr[2:0];
        illegal_in  = i_req_we ? i_func_3[2] : (i_func_3 == 3'b111);
        misalign_in = 1'b0;
        strb_in     = 8'h00;
        case (i_func_3[1:0])
            2'b00: begin
                misalign_in = 1'b0;
                strb_in     = 8'h01 << off_in;
            end
            2'b01: begin
                misalign_in = off_in[0];
                strb_in     = 8'h03 << off_in;
            end
            2'b10: begin
                misalign_in = |off_in[1:0];
                strb_in     = 8'h0F << off_in;
            end
            default: begin
                misalign_in = |off_in;
                strb_in     = 8'hFF;
            end
        endcase
    end

    // Once the REQ+WAIT budget is used up the counter stays at or past
    // CNT_LAST, so a grant on the last cycle still leaves one WAIT cycle.
    assign timeout_hit = (cnt_q >= CNT_LAST);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    accept  = 1'b1;
                    state_d = (illegal_in || misalign_in) ? RESP : REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            we_q       <= 1'b0;
            func3_q    <= 3'b000;
            off_q      <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 8'h00;
            rdata_q    <= '0;
            load_ma_q  <= 1'b0;
            store_ma_q <= 1'b0;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                we_q       <= i_req_we;
                func3_q    <= i_func_3;
                off_q      <= off_in;
                addr_q     <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
                wdata_q    <= i_wdata << {off_in, 3'b000};
                wstrb_q    <= i_req_we ? strb_in : 8'h00;
                rdata_q    <= '0;
                illegal_q  <= illegal_in;
                load_ma_q  <= !illegal_in && misalign_in && !i_req_we;
                store_ma_q <= !illegal_in && misalign_in && i_req_we;
                fault_q    <= 1'b0;
                cnt_q      <= '0;
            end else if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == WAIT && i_mem_rvalid && !we_q) begin
                rdata_q <= i_mem_rdata;
            end

            if (expire) begin
                fault_q <= 1'b1;
            end

            if (state_q == RESP && i_rsp_ready) begin
                load_ma_q  <= 1'b0;
                store_ma_q <= 1'b0;
                illegal_q  <= 1'b0;
                fault_q    <= 1'b0;
            end
        end
    end

    assign o_req_ready       = (state_q == IDLE);
    assign o_mem_req         = (state_q == REQ);
    assign o_mem_we          = (state_q == REQ) && we_q;
    assign o_mem_addr        = addr_q;
    assign o_mem_wdata       = wdata_q;
    assign o_mem_wstrb       = wstrb_q;
    assign o_rsp_valid       = (state_q == RESP);
    assign o_rsp_rdata       = rdata_q;
    assign o_rsp_func_3      = func3_q;
    assign o_rsp_addr_offset = off_q;
    assign o_load_addr_ma    = load_ma_q;
    assign o_store_addr_ma   = store_ma_q;
    assign o_illegal_instr   = illegal_q;
    assign o_access_fault    = fault_q;

endmodule
